// File: rtl/spram_arb_pkg.sv
// Shared constants for the two-requester single-port RAM arbiter.
// Holds the width defaults, the FSM state encoding and the requester-id type.
package spram_arb_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int ID_W       = 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant; the last-grant pointer is kept by the parent.
module rr_arbiter_2 (
  input  logic req_valid_0,
  input  logic req_valid_1,
  input  logic last_grant,
  output logic gnt_0,
  output logic gnt_1
);

  // On a tie the requester that was not served last wins.
  assign gnt_0 = req_valid_0 && (!req_valid_1 || last_grant);
  assign gnt_1 = req_valid_1 && (!req_valid_0 || !last_grant);

endmodule

// File: rtl/single_port_ram.sv
// 8 x 8-bit synchronous single-port RAM with registered read data.
module single_port_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[address] <= data_in;
      else    data_out     <= mem[address];
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter and sequencer serialising two masters onto one single-port RAM.
// One command is in flight at a time: IDLE accepts, ISSUE drives the RAM, RDWAIT returns read data.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic              req_we_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt_0, gnt_1;
  logic              accept, issue, rdwait;
  logic              cmd_we_p1;
  logic [ADDR_W-1:0] cmd_addr_p1;
  logic [DATA_W-1:0] cmd_wdata_p1;
  req_id_t           cmd_id_p1;
  logic [DATA_W-1:0] rdata_hold_0, rdata_hold_1;

  rr_arbiter_2 u_arb (
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .last_grant  (last_grant),
    .gnt_0       (gnt_0),
    .gnt_1       (gnt_1)
  );

  assign req_ready_0 = rst_n && (state == ST_IDLE) && gnt_0;
  assign req_ready_1 = rst_n && (state == ST_IDLE) && gnt_1;
  assign accept      = req_ready_0 || req_ready_1;

  // Gating with rst_n keeps a reset taken mid-transaction from writing the RAM or emitting a response.
  assign issue  = rst_n && (state == ST_ISSUE);
  assign rdwait = rst_n && (state == ST_RDWAIT);

  assign ram_en    = issue;
  assign ram_we    = issue && cmd_we_p1;
  assign ram_addr  = issue ? cmd_addr_p1  : '0;
  assign ram_wdata = issue ? cmd_wdata_p1 : '0;

  assign rsp_valid_0 = rdwait && (cmd_id_p1 == req_id_t'(0));
  assign rsp_valid_1 = rdwait && (cmd_id_p1 == req_id_t'(1));
  assign rsp_rdata_0 = rsp_valid_0 ? ram_rdata : rdata_hold_0;
  assign rsp_rdata_1 = rsp_valid_1 ? ram_rdata : rdata_hold_1;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      rdata_hold_0 <= '0;
      rdata_hold_1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_ISSUE;
            last_grant <= req_ready_1;
          end
        end
        ST_ISSUE: state <= cmd_we_p1 ? ST_IDLE : ST_RDWAIT;
        default:  state <= ST_IDLE;
      endcase
      if (rsp_valid_0) rdata_hold_0 <= ram_rdata;
      if (rsp_valid_1) rdata_hold_1 <= ram_rdata;
    end
  end

  // Command capture stage: loaded on the accepting handshake, consumed in ISSUE.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_we_p1    <= req_ready_1 ? req_we_1    : req_we_0;
      cmd_addr_p1  <= req_ready_1 ? req_addr_1  : req_addr_0;
      cmd_wdata_p1 <= req_ready_1 ? req_wdata_1 : req_wdata_0;
      cmd_id_p1    <= req_id_t'(req_ready_1);
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter driving a single_port_ram instance.
module tb_spram_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_0, req_ready_0, req_we_0;
  logic [AW-1:0] req_addr_0;
  logic [DW-1:0] req_wdata_0;
  logic          rsp_valid_0;
  logic [DW-1:0] rsp_rdata_0;
  logic          req_valid_1, req_ready_1, req_we_1;
  logic [AW-1:0] req_addr_1;
  logic [DW-1:0] req_wdata_1;
  logic          rsp_valid_1;
  logic [DW-1:0] rsp_rdata_1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_0 (req_valid_0),
    .req_ready_0 (req_ready_0),
    .req_we_0    (req_we_0),
    .req_addr_0  (req_addr_0),
    .req_wdata_0 (req_wdata_0),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_rdata_0 (rsp_rdata_0),
    .req_valid_1 (req_valid_1),
    .req_ready_1 (req_ready_1),
    .req_we_1    (req_we_1),
    .req_addr_1  (req_addr_1),
    .req_wdata_1 (req_wdata_1),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_rdata_1 (rsp_rdata_1),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .busy        (busy)
  );

  single_port_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk      (clk),
    .en       (ram_en),
    .we       (ram_we),
    .address  (ram_addr),
    .data_in  (ram_wdata),
    .data_out (ram_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    req_valid_0 = 1'b1;
    req_we_0    = 1'b0;
    req_addr_0  = '0;
    req_wdata_0 = '0;
    req_valid_1 = 1'b0;
    req_we_1    = 1'b0;
    req_addr_1  = '0;
    req_wdata_1 = '0;

    // Reset: ready suppressed even with a valid request present
    step();
    step();
    samp();
    check_eq("rst_ready0", 32'(req_ready_0), 0);
    check_eq("rst_busy",   32'(busy), 0);
    check_eq("rst_ram_en", 32'(ram_en), 0);
    check_eq("rst_ram_we", 32'(ram_we), 0);
    check_eq("rst_addr",   32'(ram_addr), 0);
    check_eq("rst_wdata",  32'(ram_wdata), 0);
    check_eq("rst_rsp_v0", 32'(rsp_valid_0), 0);
    check_eq("rst_rsp_v1", 32'(rsp_valid_1), 0);
    check_eq("rst_rdata0", 32'(rsp_rdata_0), 0);
    check_eq("rst_rdata1", 32'(rsp_rdata_1), 0);
    rst_n       = 1'b1;
    req_valid_0 = 1'b0;
    step();

    // Fill: requester 0 writes A0+i, one accept every two cycles
    for (int i = 0; i < 8; i++) begin
      req_valid_0 = 1'b1;
      req_we_0    = 1'b1;
      req_addr_0  = AW'(i);
      req_wdata_0 = DW'(8'hA0 + i);
      samp();
      check_eq("wr_ready",   32'(req_ready_0), 1);
      check_eq("wr_idle_en", 32'(ram_en), 0);
      step();
      samp();
      check_eq("wr_iss_ready", 32'(req_ready_0), 0);
      check_eq("wr_iss_en",    32'(ram_en), 1);
      check_eq("wr_iss_we",    32'(ram_we), 1);
      check_eq("wr_iss_addr",  32'(ram_addr), i);
      check_eq("wr_iss_wdata", 32'(ram_wdata), 8'hA0 + i);
      check_eq("wr_iss_busy",  32'(busy), 1);
      check_eq("wr_no_rsp",    32'(rsp_valid_0 | rsp_valid_1), 0);
      step();
    end
    req_valid_0 = 1'b0;

    // Requester 1 reads back every address
    for (int i = 0; i < 8; i++) begin
      req_valid_1 = 1'b1;
      req_we_1    = 1'b0;
      req_addr_1  = AW'(i);
      samp();
      check_eq("rd_ready1", 32'(req_ready_1), 1);
      check_eq("rd_ready0", 32'(req_ready_0), 0);
      step();
      samp();
      check_eq("rd_iss_en",   32'(ram_en), 1);
      check_eq("rd_iss_we",   32'(ram_we), 0);
      check_eq("rd_iss_addr", 32'(ram_addr), i);
      step();
      samp();
      check_eq("rd_rsp_v1",   32'(rsp_valid_1), 1);
      check_eq("rd_rsp_d1",   32'(rsp_rdata_1), 8'hA0 + i);
      check_eq("rd_rsp_v0",   32'(rsp_valid_0), 0);
      check_eq("rd_wait_en",  32'(ram_en), 0);
      check_eq("rd_wait_rdy", 32'(req_ready_1), 0);
      step();
    end
    req_valid_1 = 1'b0;
    samp();
    check_eq("hold_v1",    32'(rsp_valid_1), 0);
    check_eq("hold_d1",    32'(rsp_rdata_1), 8'hA7);
    check_eq("hold_d0",    32'(rsp_rdata_0), 0);
    check_eq("idle_busy",  32'(busy), 0);
    step();

    // Contention: both read continuously, grants alternate starting with 0
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 3'd3;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 3'd5;
    for (int g = 0; g < 4; g++) begin
      logic e0;
      e0 = (g % 2 == 0);
      samp();
      check_eq("rr_ready0", 32'(req_ready_0), 32'(e0));
      check_eq("rr_ready1", 32'(req_ready_1), 32'(!e0));
      step();
      samp();
      check_eq("rr_addr", 32'(ram_addr), e0 ? 3 : 5);
      step();
      samp();
      check_eq("rr_rsp_v0", 32'(rsp_valid_0), 32'(e0));
      check_eq("rr_rsp_v1", 32'(rsp_valid_1), 32'(!e0));
      check_eq("rr_rsp_d", 32'(e0 ? rsp_rdata_0 : rsp_rdata_1), e0 ? 8'hA3 : 8'hA5);
      step();
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;

    // Write from 0 and read from 1 of the same address: write first
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 3'd2; req_wdata_0 = 8'h5A;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 3'd2;
    samp();
    check_eq("wr_rd_ready0", 32'(req_ready_0), 1);
    check_eq("wr_rd_ready1", 32'(req_ready_1), 0);
    step();
    req_valid_0 = 1'b0;
    samp();
    check_eq("wr_rd_we",    32'(ram_we), 1);
    check_eq("wr_rd_wdata", 32'(ram_wdata), 8'h5A);
    step();
    samp();
    check_eq("wr_rd_ready1b", 32'(req_ready_1), 1);
    step();
    samp();
    check_eq("wr_rd_iss_we", 32'(ram_we), 0);
    step();
    samp();
    check_eq("wr_rd_rsp_v1", 32'(rsp_valid_1), 1);
    check_eq("wr_rd_rsp_d1", 32'(rsp_rdata_1), 8'h5A);
    check_eq("wr_rd_rsp_v0", 32'(rsp_valid_0), 0);
    step();
    req_valid_1 = 1'b0;

    // Reset during RDWAIT drops the response
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 3'd6;
    samp();
    check_eq("rstrd_ready1", 32'(req_ready_1), 1);
    step();
    step();
    rst_n = 1'b0;
    samp();
    check_eq("rstrd_rsp_v1", 32'(rsp_valid_1), 0);
    check_eq("rstrd_en",     32'(ram_en), 0);
    step();
    samp();
    check_eq("rstrd_busy",   32'(busy), 0);
    check_eq("rstrd_en2",    32'(ram_en), 0);
    check_eq("rstrd_addr",   32'(ram_addr), 0);
    check_eq("rstrd_d1",     32'(rsp_rdata_1), 0);
    check_eq("rstrd_d0",     32'(rsp_rdata_0), 0);
    check_eq("rstrd_ready1b", 32'(req_ready_1), 0);
    rst_n = 1'b1;
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 3'd1;
    req_addr_1 = 3'd7;
    #1;
    check_eq("tie_ready0", 32'(req_ready_0), 1);
    check_eq("tie_ready1", 32'(req_ready_1), 0);
    step();
    samp();
    check_eq("tie_addr0", 32'(ram_addr), 1);
    step();
    samp();
    check_eq("tie_rsp_v0", 32'(rsp_valid_0), 1);
    check_eq("tie_rsp_d0", 32'(rsp_rdata_0), 8'hA1);
    req_valid_0 = 1'b0;
    step();
    samp();
    check_eq("tie_ready1b", 32'(req_ready_1), 1);
    step();
    step();
    samp();
    check_eq("tie_rsp_v1", 32'(rsp_valid_1), 1);
    check_eq("tie_rsp_d1", 32'(rsp_rdata_1), 8'hA7);
    step();
    req_valid_1 = 1'b0;

    // Reset during ISSUE of a write leaves the RAM untouched
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 3'd4; req_wdata_0 = 8'hFF;
    samp();
    check_eq("rstwr_ready0", 32'(req_ready_0), 1);
    step();
    req_valid_0 = 1'b0;
    rst_n = 1'b0;
    samp();
    check_eq("rstwr_en", 32'(ram_en), 0);
    check_eq("rstwr_we", 32'(ram_we), 0);
    step();
    rst_n = 1'b1;
    step();
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 3'd4;
    samp();
    check_eq("rstwr_rd_ready0", 32'(req_ready_0), 1);
    step();
    step();
    samp();
    check_eq("rstwr_rsp_v0", 32'(rsp_valid_0), 1);
    check_eq("rstwr_rsp_d0", 32'(rsp_rdata_0), 8'hA4);
    step();
    req_valid_0 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
